// File: rtl/uart_rx_fifo.sv
// UART receiver: oversampled start/data/parity/stop detection feeding a
// show-ahead RX FIFO that stores a parity- and framing-error flag with each word.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_ovr
);

  localparam int unsigned BAUD_TICK = BAUD * OVERSAMPLE;
  localparam int unsigned DIV_RAW   = (CLK_HZ + BAUD_TICK / 2) / BAUD_TICK;
  localparam int unsigned DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW        = $clog2(DIV + 1);
  localparam int unsigned TW        = $clog2(OVERSAMPLE);
  localparam int unsigned BW        = $clog2(DATA_BITS + 1);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned WW        = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Line synchroniser
  logic rx_meta, rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Oversample tick generator
  logic [DW-1:0] div_cnt;
  logic          tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DW'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Receive FSM
  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_q, ferr_q;
  logic                 mid, sample, frame_done;
  logic                 push_q;
  logic [WW-1:0]        word_q;

  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    // START counts half a bit to reach mid-bit; every later bit is a full period
    mid        = (state == START) ? (tick_cnt == TW'(OVERSAMPLE / 2 - 1))
                                  : (tick_cnt == TW'(OVERSAMPLE - 1));
    sample     = tick && (state != IDLE) && mid;
    case (state)
      IDLE:  if (tick && !rx_s) state_n = START;
      START: if (sample) state_n = rx_s ? IDLE : DATA;
      DATA:  if (sample && bit_cnt == BW'(DATA_BITS - 1))
               state_n = (PARITY != 0) ? PAR : STOP;
      PAR:   if (sample) state_n = STOP;
      STOP:  if (sample && bit_cnt == BW'(STOP_BITS - 1)) begin
               state_n    = IDLE;
               frame_done = 1'b1;
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      push_q   <= 1'b0;
      word_q   <= '0;
    end else begin
      state  <= state_n;
      push_q <= frame_done;
      if (state == IDLE) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        perr_q   <= 1'b0;
        ferr_q   <= 1'b0;
      end else if (tick) begin
        tick_cnt <= sample ? '0 : tick_cnt + 1'b1;
      end
      if (sample) begin
        case (state)
          DATA: begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == BW'(DATA_BITS - 1)) ? '0 : bit_cnt + 1'b1;
          end
          PAR:  perr_q <= (PARITY == 1) ? ~^{shift, rx_s} : ^{shift, rx_s};
          STOP: begin
            ferr_q  <= ferr_q | ~rx_s;
            bit_cnt <= bit_cnt + 1'b1;
          end
          default: ;
        endcase
      end
      if (frame_done) word_q <= {perr_q, ferr_q | ~rx_s, shift};
    end
  end

  // Show-ahead FIFO
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, wr, ovr_set;

  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW + 1)'(FIFO_DEPTH));
    pop     = rd_en && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    wr      = push_q && (!full || pop);
    ovr_set = push_q && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= word_q;
  end

  always_comb begin
    rd_valid   = !empty;
    fifo_count = count;
    {rd_perr, rd_ferr, rd_data} = empty ? '0 : mem[rd_ptr];
  end

endmodule
